// File: rtl/scared_ghost_sprite_fetch_if.sv
// Bundle of the scan, control-pulse, sprite-ROM and palette-output signals of the scared-ghost fetch stage.
// The master side drives scan/ghost position, event pulses and ROM data; the slave side is the fetch stage.
interface scared_ghost_sprite_fetch_if #(
    parameter int unsigned ROM_AW = 9
);
    logic              frame_tick;
    logic              power_pellet;
    logic              ghost_eaten;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        GhostX;
    logic [9:0]        GhostY;
    logic [ROM_AW-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        index;
    logic              pixel_on;
    logic              scared;
    logic              flash_white;

    modport master (
        output frame_tick, power_pellet, ghost_eaten, DrawX, DrawY, GhostX, GhostY, rom_data,
        input  rom_addr, index, pixel_on, scared, flash_white
    );

    modport slave (
        input  frame_tick, power_pellet, ghost_eaten, DrawX, DrawY, GhostX, GhostY, rom_data,
        output rom_addr, index, pixel_on, scared, flash_white
    );
endinterface

// File: rtl/scared_ghost_sprite_fetch.sv
// Frightened-mode timer (NORMAL/SCARED/FLASH) for one ghost plus the 2-stage scan-to-palette-index
// pipeline that addresses the frightened-ghost sprite ROM.
module scared_ghost_sprite_fetch #(
    parameter int unsigned SPRITE_W        = 16,
    parameter int unsigned SPRITE_H        = 16,
    parameter int unsigned SCARED_FRAMES   = 360,
    parameter int unsigned FLASH_FRAMES    = 120,
    parameter int unsigned FLASH_HALF      = 15,
    parameter int unsigned ANIM_DIV        = 8,
    parameter logic [3:0]  TRANSPARENT_IDX = 4'h1
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    scared_ghost_sprite_fetch_if.slave  bus
);
    localparam int unsigned CNT_W   = $clog2(SCARED_FRAMES + 1);
    localparam int unsigned FLASH_W = $clog2(FLASH_HALF + 1);
    localparam int unsigned ANIM_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned COL_W   = $clog2(SPRITE_W);
    localparam int unsigned ROW_W   = $clog2(SPRITE_H);

    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(SCARED_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_FLASH = CNT_W'(FLASH_FRAMES);
    localparam logic [FLASH_W-1:0] FLASH_END = FLASH_W'(FLASH_HALF - 1);
    localparam logic [ANIM_W-1:0]  ANIM_END  = ANIM_W'(ANIM_DIV - 1);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_SCARED,
        ST_FLASH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               flash_phase_q, flash_phase_d;
    logic [ANIM_W-1:0]  anim_cnt_q, anim_cnt_d;
    logic               anim_q, anim_d;
    logic               scared_q, scared_d;
    logic               flash_white_q, flash_white_d;

    logic               in_box_p1_q, in_box_p1_d;
    logic               scared_p1_q, scared_p1_d;
    logic [3:0]         index_q, index_d;
    logic               pixel_on_q, pixel_on_d;

    logic [10:0]        dx, dy;
    logic               in_box;

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;
        anim_d        = anim_q;
        anim_cnt_d    = anim_cnt_q;

        // Priority: eaten > pellet reload > frame tick.
        if (bus.ghost_eaten && (state_q != ST_NORMAL)) begin
            state_d   = ST_NORMAL;
            counter_d = '0;
        end else if (bus.power_pellet) begin
            state_d       = ST_SCARED;
            counter_d     = CNT_FULL;
            flash_phase_d = 1'b0;
            flash_cnt_d   = '0;
        end else if (bus.frame_tick) begin
            case (state_q)
                ST_SCARED: begin
                    counter_d = counter_q - CNT_W'(1);
                    if (counter_d == CNT_FLASH) begin
                        state_d       = ST_FLASH;
                        flash_phase_d = 1'b0;
                        flash_cnt_d   = '0;
                    end
                end
                ST_FLASH: begin
                    counter_d = counter_q - CNT_W'(1);
                    if (flash_cnt_q == FLASH_END) begin
                        flash_phase_d = ~flash_phase_q;
                        flash_cnt_d   = '0;
                    end else begin
                        flash_cnt_d = flash_cnt_q + FLASH_W'(1);
                    end
                    if (counter_d == '0) begin
                        state_d = ST_NORMAL;
                    end
                end
                default: ;
            endcase
        end

        if (state_d == ST_NORMAL) begin
            anim_d     = 1'b0;
            anim_cnt_d = '0;
        end else if (bus.frame_tick && !bus.power_pellet && (state_q != ST_NORMAL)) begin
            if (anim_cnt_q == ANIM_END) begin
                anim_d     = ~anim_q;
                anim_cnt_d = '0;
            end else begin
                anim_cnt_d = anim_cnt_q + ANIM_W'(1);
            end
        end

        scared_d      = (state_d != ST_NORMAL);
        flash_white_d = (state_d == ST_FLASH) && flash_phase_d;
    end

    // Zero-extended subtraction: bit 10 set means the scan is left of / above the sprite.
    assign dx     = {1'b0, bus.DrawX} - {1'b0, bus.GhostX};
    assign dy     = {1'b0, bus.DrawY} - {1'b0, bus.GhostY};
    assign in_box = !dx[10] && !dy[10] && (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));

    always_comb begin
        in_box_p1_d = in_box;
        scared_p1_d = scared_q;
        index_d     = bus.rom_data;
        pixel_on_d  = in_box_p1_q && scared_p1_q && (bus.rom_data != TRANSPARENT_IDX);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_NORMAL;
            counter_q     <= '0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
            anim_cnt_q    <= '0;
            anim_q        <= 1'b0;
            scared_q      <= 1'b0;
            flash_white_q <= 1'b0;
            in_box_p1_q   <= 1'b0;
            scared_p1_q   <= 1'b0;
            index_q       <= '0;
            pixel_on_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
            anim_cnt_q    <= anim_cnt_d;
            anim_q        <= anim_d;
            scared_q      <= scared_d;
            flash_white_q <= flash_white_d;
            in_box_p1_q   <= in_box_p1_d;
            scared_p1_q   <= scared_p1_d;
            index_q       <= index_d;
            pixel_on_q    <= pixel_on_d;
        end
    end

    assign bus.rom_addr    = {anim_q, dy[ROW_W-1:0], dx[COL_W-1:0]};
    assign bus.index       = index_q;
    assign bus.pixel_on    = pixel_on_q;
    assign bus.scared      = scared_q;
    assign bus.flash_white = flash_white_q;
endmodule

// File: tb/tb_scared_ghost_sprite_fetch.sv
// Scoreboard bench: stimulus pushes expectations, a monitor pops and compares at negedge+2.
module tb_scared_ghost_sprite_fetch;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    scared_ghost_sprite_fetch_if #(.ROM_AW(9)) bus ();

    scared_ghost_sprite_fetch #(
        .SPRITE_W(16), .SPRITE_H(16), .SCARED_FRAMES(360), .FLASH_FRAMES(120),
        .FLASH_HALF(15), .ANIM_DIV(8), .TRANSPARENT_IDX(4'h1)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    // Behavioural sync ROM, 1-cycle latency.
    logic [3:0] rom_mem [512];
    always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr];

    function automatic logic [3:0] rom_init(int unsigned a);
        int unsigned s;
        s = (a & 15) + ((a >> 4) & 15) + 2 + 4 * ((a >> 8) & 1);
        return 4'(s);
    endfunction

    // kind 0: scared/flash_white, kind 1: rom_addr, kind 2: index/pixel_on now
    typedef struct {
        string      nm;
        int         kind;
        logic       b;
        logic       c;
        logic [3:0] idx;
        logic [8:0] addr;
    } st_t;
    typedef struct {
        string      nm;
        logic [3:0] idx;
        logic       on;
    } px_t;

    st_t st_q[$];
    px_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    logic stim_v = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic tb_scared = 1'b0;

    always @(posedge Clk) begin
        v1 <= stim_v;
        v2 <= v1;
    end

    always begin
        @(negedge Clk);
        #2;
        while (st_q.size() > 0) begin
            st_t s;
            s = st_q.pop_front();
            checks++;
            case (s.kind)
                0: if (bus.scared !== s.b || bus.flash_white !== s.c) begin
                    errors++;
                    $display("FAIL %s: scared=%b flash_white=%b, expected scared=%b flash_white=%b",
                             s.nm, bus.scared, bus.flash_white, s.b, s.c);
                end
                1: if (bus.rom_addr !== s.addr) begin
                    errors++;
                    $display("FAIL %s: rom_addr=%h, expected %h", s.nm, bus.rom_addr, s.addr);
                end
                default: if (bus.index !== s.idx || bus.pixel_on !== s.b) begin
                    errors++;
                    $display("FAIL %s: index=%h pixel_on=%b, expected index=%h pixel_on=%b",
                             s.nm, bus.index, bus.pixel_on, s.idx, s.b);
                end
            endcase
        end
        if (v2) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected: index=%h pixel_on=%b, expected no output",
                         bus.index, bus.pixel_on);
            end else begin
                px_t p;
                p = sb_q.pop_front();
                if (bus.index !== p.idx || bus.pixel_on !== p.on) begin
                    errors++;
                    $display("FAIL %s: index=%h pixel_on=%b, expected index=%h pixel_on=%b",
                             p.nm, bus.index, bus.pixel_on, p.idx, p.on);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge Clk);
            bus.frame_tick = 1'b1;
            @(negedge Clk);
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic pulse(input logic pp, input logic ge, input logic ft);
        @(negedge Clk);
        bus.power_pellet = pp;
        bus.ghost_eaten  = ge;
        bus.frame_tick   = ft;
        @(negedge Clk);
        bus.power_pellet = 1'b0;
        bus.ghost_eaten  = 1'b0;
        bus.frame_tick   = 1'b0;
    endtask

    task automatic chk_st(input string nm, input logic sc, input logic fw);
        st_q.push_back('{nm, 0, sc, fw, 4'h0, 9'h0});
        @(negedge Clk);
    endtask

    task automatic chk_out(input string nm, input logic [3:0] idx, input logic on);
        st_q.push_back('{nm, 2, on, 1'b0, idx, 9'h0});
    endtask

    task automatic chk_addr(input string nm, input logic [8:0] a);
        st_q.push_back('{nm, 1, 1'b0, 1'b0, 4'h0, a});
    endtask

    task automatic pix(input string nm, input int gx, input int gy, input int x, input int y,
                       input logic [8:0] a, input logic inb);
        logic [3:0] d;
        @(negedge Clk);
        bus.GhostX = 10'(gx);
        bus.GhostY = 10'(gy);
        bus.DrawX  = 10'(x);
        bus.DrawY  = 10'(y);
        stim_v     = 1'b1;
        d = rom_mem[a];
        chk_addr({nm, "_addr"}, a);
        sb_q.push_back('{nm, d, inb && tb_scared && (d != 4'h1)});
        @(negedge Clk);
        stim_v = 1'b0;
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom_mem[i] = rom_init(i);
        bus.frame_tick   = 1'b0;
        bus.power_pellet = 1'b0;
        bus.ghost_eaten  = 1'b0;
        bus.GhostX = 10'd100;
        bus.GhostY = 10'd50;
        bus.DrawX  = 10'd0;
        bus.DrawY  = 10'd0;

        idle(3);
        chk_out("reset_out", 4'h0, 1'b0);
        chk_st("reset_status", 1'b0, 1'b0);
        Reset_n = 1'b1;
        idle(2);

        pix("not_scared", 100, 50, 100, 50, 9'h000, 1'b1);

        pulse(1'b1, 1'b0, 1'b0);
        tb_scared = 1'b1;
        chk_st("pellet_scared", 1'b1, 1'b0);

        rom_mem[9'h037] = 4'h0;
        pix("opaque_idx0", 100, 50, 107, 53, 9'h037, 1'b1);
        rom_mem[9'h037] = 4'h1;
        pix("transparent", 100, 50, 107, 53, 9'h037, 1'b1);
        pix("left_of_box", 100, 50, 99, 53, 9'h03F, 1'b0);
        pix("right_of_box", 100, 50, 116, 53, 9'h030, 1'b0);
        pix("below_box", 100, 50, 107, 66, 9'h007, 1'b0);
        pix("corner_br", 100, 50, 115, 65, 9'h0FF, 1'b1);
        pix("corner_tl", 100, 50, 100, 50, 9'h000, 1'b1);
        pix("transp_default", 100, 50, 110, 55, 9'h05A, 1'b1);
        pix("screen_edge", 630, 50, 639, 53, 9'h039, 1'b1);

        tick(7);
        pix("anim_still0", 100, 50, 100, 50, 9'h000, 1'b1);
        tick(1);
        pix("anim_toggled", 100, 50, 100, 50, 9'h100, 1'b1);
        tick(232);
        chk_st("flash_entry", 1'b1, 1'b0);
        tick(14);
        chk_st("flash_pre_toggle", 1'b1, 1'b0);
        tick(1);
        chk_st("flash_white_on", 1'b1, 1'b1);
        tick(15);
        chk_st("flash_white_off", 1'b1, 1'b0);
        tick(89);
        chk_st("tick359", 1'b1, 1'b1);
        tick(1);
        chk_st("scare_end", 1'b0, 1'b0);
        tb_scared = 1'b0;

        // Reload during flash with a coincident tick must not decrement.
        pulse(1'b1, 1'b0, 1'b0);
        tick(285);
        chk_st("before_reload", 1'b1, 1'b1);
        pulse(1'b1, 1'b0, 1'b1);
        chk_st("reload", 1'b1, 1'b0);
        tick(359);
        chk_st("reload_tick359", 1'b1, 1'b1);
        tick(1);
        chk_st("reload_end", 1'b0, 1'b0);

        pulse(1'b1, 1'b0, 1'b0);
        tick(3);
        chk_st("eaten_pre", 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        chk_st("eaten_beats_pellet", 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk_st("eaten_in_normal", 1'b0, 1'b0);

        pulse(1'b1, 1'b0, 1'b0);
        tick(10);
        @(negedge Clk);
        bus.GhostX = 10'd100;
        bus.GhostY = 10'd50;
        bus.DrawX  = 10'd100;
        bus.DrawY  = 10'd50;
        chk_addr("anim_before_reset", 9'h100);
        chk_st("scared_before_reset", 1'b1, 1'b0);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        chk_out("midreset_out", 4'h0, 1'b0);
        chk_addr("midreset_anim", 9'h000);
        chk_st("midreset_status", 1'b0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick(1);
        chk_st("after_reset", 1'b0, 1'b0);
        chk_addr("after_reset_anim", 9'h000);

        idle(6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
